// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Issue stage that sits in front of the combinational 4-bit ALU slice chain.
//   Commands {a, b, op, cin} are buffered in a DEPTH-entry FIFO (valid/ready).
//   The FIFO feeds a registered operand stage (S1) that drives the ALU. The
//   ALU's zero/overflow flags come back and are captured in a result register
//   (S2), which is drained through a second valid/ready handshake.
//
// Optional feature (compile-time macro ALU_ISSUE_OVF_CNT_EN):
//   When it is defined, the design adds the ovf_count port. This is a
//   saturating count of delivered results that had overflow = 1.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        command handshake (in_ready depends on state only)
//   in_a, in_b, in_op, in_cin  command fields
//   alu_a, alu_b, alu_op, alu_cin  registered operands to the ALU
//   alu_zero, alu_overflow   flags returned combinationally by the ALU
//   res_valid/res_ready      result handshake
//   res_zero, res_overflow   captured flags
//   level                    FIFO occupancy (0..DEPTH)
//   ovf_count                overflow result counter (macro builds only)
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_a,
    input  logic [3:0]                 in_b,
    input  logic [1:0]                 in_op,
    input  logic                       in_cin,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [1:0]                 alu_op,
    output logic                       alu_cin,
    input  logic                       alu_zero,
    input  logic                       alu_overflow,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       res_zero,
    output logic                       res_overflow,
    output logic [$clog2(DEPTH):0]     level
`ifdef ALU_ISSUE_OVF_CNT_EN
    ,
    output logic [CNT_W-1:0]           ovf_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Command word layout: {a[3:0], b[3:0], op[1:0], cin}
    logic [10:0]      mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             s1_valid_reg;
    logic [10:0]      head;

    logic push;
    logic pop;
    logic s1_adv;
    logic res_take;

    // Full is judged from registered occupancy only. A pop in the same cycle
    // therefore does not free a slot for a push until the next cycle.
    assign in_ready = (level_reg != LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign res_take = res_valid && res_ready;
    // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
    assign s1_adv   = s1_valid_reg && (!res_valid || res_ready);
    assign pop      = (level_reg != '0) && (!s1_valid_reg || s1_adv);
    assign head     = mem[rd_ptr_reg];
    assign level    = level_reg;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Storage is not reset. Only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_a, in_b, in_op, in_cin};
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            level_reg <= level_next;
        end
    end

    // S1: operand register that drives the ALU. It holds its value while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_cin      <= 1'b0;
        end else if (pop) begin
            s1_valid_reg <= 1'b1;
            {alu_a, alu_b, alu_op, alu_cin} <= head;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // S2: result register that captures the ALU flags for the command leaving S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_zero     <= 1'b0;
            res_overflow <= 1'b0;
        end else if (s1_adv) begin
            res_valid    <= 1'b1;
            res_zero     <= alu_zero;
            res_overflow <= alu_overflow;
        end else if (res_take) begin
            res_valid    <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_OVF_CNT_EN
    // Counts a result when it is delivered, not when it is captured. The count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (res_take && res_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue. Each accepted command pushes its expected
// flags into a scoreboard queue. A separate monitor pops that queue and
// compares on every delivered result. Directed tests are followed by
// randomized traffic.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic       in_cin;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_cin;
    logic       alu_zero;
    logic       alu_overflow;
    logic       res_valid;
    logic       res_ready;
    logic       res_zero;
    logic       res_overflow;
    logic [2:0] level;
`ifdef ALU_ISSUE_OVF_CNT_EN
    logic [CNT_W-1:0] ovf_count;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [1:0] exp_q[$];        // {zero, overflow}
    int unsigned ovf_model = 0;  // delivered overflow results, saturating

    alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_zero(res_zero), .res_overflow(res_overflow),
        .level(level)
`ifdef ALU_ISSUE_OVF_CNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    // ALU stub
    assign alu_zero     = (alu_a == alu_b);
    assign alu_overflow = alu_cin;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic cin);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_cin   = cin;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !res_valid) break;
            step();
        end
        chk("drain_all_delivered", exp_q.size(), 0);
        chk("drain_res_idle", int'(res_valid), 0);
    endtask

    // Stimulus observer: records the expected result of every accepted command.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back({(in_a == in_b), in_cin});
            $display("push a=%h b=%h op=%h cin=%0d", in_a, in_b, in_op, in_cin);
        end
    end

    // Result monitor: compares every result that will be taken at the next edge.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("result_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("result zero=%0d ovf=%0d", res_zero, res_overflow);
                chk("result_zero", int'(res_zero), int'(e[1]));
                chk("result_ovf", int'(res_overflow), int'(e[0]));
                if (e[0] && ovf_model < (2 ** CNT_W - 1)) ovf_model++;
            end
        end
    end

    initial begin
        int pushed;
        logic [3:0] sa;
        logic [3:0] sb;
        rst = 1'b1;
        res_ready = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        #2;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_level", int'(level), 0);
        chk("reset_res_valid", int'(res_valid), 0);
        chk("reset_alu_a", int'(alu_a), 0);
`ifdef ALU_ISSUE_OVF_CNT_EN
        chk("reset_ovf_count", int'(ovf_count), 0);
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        step();

        // Single command: checks latency
        res_ready = 1'b1;
        drive(1'b1, 4'h5, 4'h5, 2'b01, 1'b1);
        step();
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        chk("single_level_after_push", int'(level), 1);
        chk("single_no_early_result", int'(res_valid), 0);
        step();
        chk("single_alu_a", int'(alu_a), 5);
        chk("single_alu_op", int'(alu_op), 1);
        chk("single_alu_cin", int'(alu_cin), 1);
        step();
        chk("single_res_valid", int'(res_valid), 1);
        chk("single_res_zero", int'(res_zero), 1);
        chk("single_res_ovf", int'(res_overflow), 1);
        step();
        chk("single_res_cleared", int'(res_valid), 0);

        // Streaming: 8 back-to-back commands at full throughput
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                chk("stream_in_ready", int'(in_ready), 1);
                drive(1'b1, 4'(i), 4'h3, 2'b10, i[0]);
            end else begin
                drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
            end
            step();
            if (i >= 2) begin
                chk("stream_res_valid", int'(res_valid), 1);
                chk("stream_res_zero", int'(res_zero), int'((i - 2) == 3));
                chk("stream_res_ovf", int'(res_overflow), (i - 2) % 2);
            end
        end
        drain();

        // Full / backpressure
        res_ready = 1'b0;
        pushed = 0;
        for (int k = 0; k < 10; k++) begin
            if (!in_ready) break;
            drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)), 1'($urandom_range(1)));
            step();
            pushed++;
        end
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        chk("full_push_count", pushed, DEPTH + 2);
        chk("full_level", int'(level), DEPTH);
        chk("full_in_ready", int'(in_ready), 0);
        chk("full_res_valid", int'(res_valid), 1);
        sa = alu_a;
        sb = alu_b;
        repeat (3) step();
        chk("stall_alu_a_stable", int'(alu_a), int'(sa));
        chk("stall_alu_b_stable", int'(alu_b), int'(sb));
        chk("stall_level", int'(level), DEPTH);

        // Push offered while full and a result drains: refused, then accepted
        drive(1'b1, 4'h9, 4'h9, 2'b11, 1'b0);
        res_ready = 1'b1;
        step();
        chk("fullpop_level_dec", int'(level), DEPTH - 1);
        chk("fullpop_in_ready", int'(in_ready), 1);
        step();
        chk("fullpop_level_after_push", int'(level), DEPTH - 1);
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        drain();

        // Reset mid-stream: S2 full, S1 full, 3 queued
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'(k + 1), 4'h0, 2'b01, 1'b1);
            step();
        end
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        chk("pre_reset_level", int'(level), 3);
        chk("pre_reset_res_valid", int'(res_valid), 1);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_alu_a", int'(alu_a), 0);
        chk("midrst_alu_b", int'(alu_b), 0);
`ifdef ALU_ISSUE_OVF_CNT_EN
        ovf_model = 0;
`endif
        @(posedge clk);
        #3 rst = 1'b0;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("postrst_no_stale", int'(res_valid), 0);
        end

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(3) != 0), 4'($urandom_range(15)), 4'($urandom_range(3)),
                  2'($urandom_range(3)), 1'($urandom_range(1)));
            res_ready = ($urandom_range(2) != 0);
            step();
        end
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        res_ready = 1'b1;
        drain();

`ifdef ALU_ISSUE_OVF_CNT_EN
        chk("ovf_count_model", int'(ovf_count), int'(ovf_model));
        pushed = 0;
        for (int k = 0; k < 400 && pushed < 300; k++) begin
            if (in_ready) pushed++;
            drive(1'b1, 4'h1, 4'h2, 2'b00, 1'b1);
            step();
        end
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0);
        drain();
        chk("ovf_count_saturated", int'(ovf_count), 2 ** CNT_W - 1);
        chk("ovf_count_model_sat", int'(ovf_count), int'(ovf_model));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Operand issue stage placed directly upstream of the 4-bit ALU slice chain. It buffers ALU commands {a, b, op, cin} in a small FIFO using a valid/ready handshake. It presents one command per cycle to the combinational ALU through a registered operand stage. It captures the ALU's zero/overflow flags into a result register that is drained through a second valid/ready handshake.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- CNT_W, 8: width of the overflow event counter.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command offered.
- in_ready  out  1  FIFO can accept (not full).
- in_a  in  4  operand A.
- in_b  in  4  operand B.
- in_op  in  2  ALU op select; passed through unmodified.
- in_cin  in  1  carry-in to slice 0.
- alu_a, alu_b  out  4 each  registered operands to the ALU.
- alu_op  out  2  registered op to the ALU.
- alu_cin  out  1  registered carry-in to the ALU.
- alu_zero  in  1  ALU zero flag (combinational from alu_*).
- alu_overflow  in  1  ALU overflow flag (combinational from alu_*).
- res_valid  out  1  result register holds a flag pair.
- res_ready  in  1  consumer takes the result.
- res_zero  out  1  captured zero flag.
- res_overflow  out  1  captured overflow flag.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- ovf_count  out  CNT_W  saturating count of delivered results with overflow=1 (present only with ALU_ISSUE_OVF_CNT_EN).

## Operation
- **FIFO.** Push when in_valid && in_ready. in_ready = (level != DEPTH), registered-state only; no same-cycle pop credit when full. Pointers wrap modulo DEPTH.
- **S1 (operand register).** s1_valid plus alu_* hold one command.
  - S1 loads from the FIFO head (pop) when the FIFO is non-empty and (!s1_valid || s1_adv).
  - s1_adv = s1_valid && (!res_valid || res_ready).
  - When S1 is not loaded, alu_* hold their last value; s1_valid clears if s1_adv occurred.
- **S2 (result register).** On s1_adv: res_zero/res_overflow <= alu_zero/alu_overflow, and res_valid <= 1. Otherwise, res_valid clears on res_valid && res_ready.
- **No bypass.** A push into an empty FIFO is not visible to S1 until the next edge.
- **Simultaneous push and pop.** Allowed whenever in_ready = 1. level is unchanged.
- **Backpressure.** With res_ready = 0 and res_valid = 1, S1 stalls and its contents and alu_* stay stable. The FIFO then fills to DEPTH, and in_ready drops.
- **Ordering.** Results emerge strictly in push order. None are dropped or duplicated.
- **Reset values (async assert, sync release).** in_ready = 1; level = 0; alu_a/alu_b/alu_op/alu_cin = 0; s1_valid = 0; res_valid = 0; res_zero = 0; res_overflow = 0; ovf_count = 0; pointers = 0.
- **Reset mid-operation.** Queued and in-flight commands are discarded without producing results.

## Timing
- **Latency.** A command accepted at edge N is on alu_* after edge N+1. Its flags are on res_* with res_valid = 1 after edge N+2. Minimum latency is 2 cycles.
- **Throughput.** One command per cycle when res_ready is held at 1.
- **Combinational path.** The ALU path alu_* -> alu_zero/alu_overflow -> S2 must fit in one cycle. No other combinational input-to-output path exists except in_ready, which depends only on state.
- **level.** Updates the cycle after a push or pop.

## Configuration
- ALU_ISSUE_OVF_CNT_EN defined:
  - ovf_count port and register exist.
  - Increments on every res_valid && res_ready && res_overflow.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- ALU_ISSUE_OVF_CNT_EN undefined: the port and register are absent; everything else is identical.

## Test plan
The bench ALU stub computes alu_zero = (alu_a == alu_b) and alu_overflow = alu_cin.
- **Single command.** Push {a=4'h5, b=4'h5, op=2'b01, cin=1} at edge 0, res_ready=1 -> alu_a=4'h5 after edge 1; res_valid=1, res_zero=1, res_overflow=1 after edge 2; res_valid=0 after edge 3.
- **Streaming.** Push 8 commands back-to-back with a=i, b=4'h3, cin=i[0], res_ready=1 -> 8 consecutive results in order; res_zero=1 only for i=3; res_overflow alternates 0,1.
- **Full/backpressure.** Hold res_ready=0 and push until in_ready=0 -> level=DEPTH (4) with S1 and S2 also occupied (6 commands total); alu_* stable; then res_ready=1 drains all 6 in order.
- **Push and pop when full.** With level=4, in_valid=1 and a result draining -> the push is refused that cycle; level goes 4->3, then the push is accepted.
- **Reset mid-stream.** Assert rst asynchronously with 3 queued commands and res_valid=1 -> immediately res_valid=0, level=0, in_ready=1, alu_*=0; no stale results after release.
- **Counter (macro defined).** Deliver 300 results with cin=1 and CNT_W=8 -> ovf_count=255 (saturated); macro undefined: the design builds without the port.
